// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes: BYTES_PER_CYCLE InvSbox lookups per cycle over 16/BYTES_PER_CYCLE cycles.
// Define INV_SUBBYTES_CHECK_EN to add forward-Sbox round-trip checking on check_err.
module inv_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         check_err
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SH = $clog2(BYTES_PER_CYCLE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Entry 0 sits in the most significant byte, so entry b is at bit offset 8*(255-b).
  localparam logic [2047:0] INV_SBOX_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TAB[{~b, 3'b000} +: 8];
  endfunction

  logic [1:0]   state_r;
  logic [1:0]   state_nxt;
  logic [CW-1:0] cnt_r;
  logic [127:0] work_r;
  logic [127:0] work_nxt;
  logic [3:0]   base_s;
  logic         in_ready_r;
  logic         out_valid_r;

  // Next-state decode for the IDLE/BUSY/DONE handshake sequence.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt = BUSY;
        else          state_nxt = IDLE;
      end
      BUSY: begin
        if (cnt_r == CW'(N - 1)) state_nxt = DONE;
        else                     state_nxt = BUSY;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
        else           state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign base_s = 4'(cnt_r) << SH;

  // Substitute the current slice of the working register.
  always_comb begin
    work_nxt = work_r;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      work_nxt[{base_s + 4'(j), 3'b000} +: 8] = inv_sbox(work_r[{base_s + 4'(j), 3'b000} +: 8]);
    end
  end

  // Control and datapath registers; handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      work_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      in_ready_r  <= (state_nxt == IDLE);
      out_valid_r <= (state_nxt == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r <= in_state;
            cnt_r  <= '0;
          end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
          end
        end
        BUSY: begin
          work_r <= work_nxt;
          cnt_r  <= cnt_r + CW'(1);
        end
        default: begin
          work_r <= work_r;
          cnt_r  <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = work_r;

`ifdef INV_SUBBYTES_CHECK_EN
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    return SBOX_TAB[{~b, 3'b000} +: 8];
  endfunction

  logic slice_err_s;
  logic check_err_r;

  // Round-trip each byte of the slice back through the forward Sbox.
  always_comb begin
    slice_err_s = 1'b0;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      slice_err_s = slice_err_s |
        (fwd_sbox(work_nxt[{base_s + 4'(j), 3'b000} +: 8]) != work_r[{base_s + 4'(j), 3'b000} +: 8]);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      check_err_r <= 1'b0;
    end else if (state_r == BUSY) begin
      check_err_r <= check_err_r | slice_err_s;
    end else begin
      check_err_r <= check_err_r;
    end
  end

  assign check_err = check_err_r;
`else
  assign check_err = 1'b0;
`endif

endmodule
